// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with two independent combinational
// lookup ports (one per fetch slot) and one synchronous write port fed by
// jump resolution. A miss predicts the sequential next PC (pc+2).
module branch_target_buffer #(
  parameter int PC_W       = 16,
  parameter int INDEX_BITS = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pc_a,
  output logic            hit_a,
  output logic [PC_W-1:0] tgt_a,
  input  logic [PC_W-1:0] pc_b,
  output logic            hit_b,
  output logic [PC_W-1:0] tgt_b,
  input  logic            we,
  input  logic [PC_W-1:0] wpc,
  input  logic [PC_W-1:0] wtgt
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = PC_W - INDEX_BITS - 1;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(2);

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [PC_W-1:0]    tgt_mem [ENTRIES];

  logic [INDEX_BITS-1:0] widx;
  logic [TAG_W-1:0]      wtag;
  logic                  wr_ok;

  logic [INDEX_BITS-1:0] idx_a, idx_b;
  logic [TAG_W-1:0]      tag_a, tag_b;

  // Bit 0 of every PC is the halfword offset; index and tag sit above it.
  assign widx  = wpc[INDEX_BITS:1];
  assign wtag  = wpc[PC_W-1:INDEX_BITS+1];
  assign wr_ok = we && !wpc[0];

  assign idx_a = pc_a[INDEX_BITS:1];
  assign tag_a = pc_a[PC_W-1:INDEX_BITS+1];
  assign idx_b = pc_b[INDEX_BITS:1];
  assign tag_b = pc_b[PC_W-1:INDEX_BITS+1];

  // Valid bits: cleared by reset (which also swallows a same-edge write), set on write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_ok) begin
      valid[widx] <= 1'b1;
    end
  end

  // Tag and target storage carry no reset; a stale entry is masked by its valid bit.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      tag_mem[widx] <= wtag;
      tgt_mem[widx] <= wtgt;
    end
  end

  // Port A lookup: odd PCs never hit; a miss falls through to the next halfword.
  always_comb begin
    hit_a = valid[idx_a] && (tag_mem[idx_a] == tag_a) && !pc_a[0];
    tgt_a = hit_a ? tgt_mem[idx_a] : pc_a + PC_STEP;
  end

  // Port B lookup, fully independent of port A.
  always_comb begin
    hit_b = valid[idx_b] && (tag_mem[idx_b] == tag_b) && !pc_b[0];
    tgt_b = hit_b ? tgt_mem[idx_b] : pc_b + PC_STEP;
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios followed by
// random traffic, all compared against a behavioural table model.
module tb_branch_target_buffer;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc_a, pc_b, tgt_a, tgt_b, wpc, wtgt;
  logic        hit_a, hit_b, we;

  int total = 0;
  int bad   = 0;

  // Reference model: one slot per halfword index, tag is everything above it.
  bit mvalid [64];
  int mtag   [64];
  int mtgt   [64];

  branch_target_buffer #(.PC_W(16), .INDEX_BITS(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .pc_a(pc_a), .hit_a(hit_a), .tgt_a(tgt_a),
    .pc_b(pc_b), .hit_b(hit_b), .tgt_b(tgt_b),
    .we(we), .wpc(wpc), .wtgt(wtgt)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic bit modelHit(input int pc);
    int i;
    i = (pc / 2) % 64;
    return (pc % 2 == 0) && mvalid[i] && (mtag[i] == pc / 128);
  endfunction

  function automatic int modelTgt(input int pc);
    if (modelHit(pc)) return mtgt[(pc / 2) % 64];
    return (pc + 2) % 65536;
  endfunction

  // One cycle: drive inputs, check lookups against the pre-edge model,
  // then apply the edge's effect to the model.
  task automatic applyStimulus(input bit r, input bit w, input int wp, input int wt,
                               input int pa, input int pb);
    @(negedge clk);
    rst_n = r; we = w; wpc = 16'(wp); wtgt = 16'(wt);
    pc_a = 16'(pa); pc_b = 16'(pb);
    #1;
    checkOutput("hit_a", 32'(hit_a), 32'(modelHit(pa)));
    checkOutput("tgt_a", 32'(tgt_a), 32'(modelTgt(pa)));
    checkOutput("hit_b", 32'(hit_b), 32'(modelHit(pb)));
    checkOutput("tgt_b", 32'(tgt_b), 32'(modelTgt(pb)));
    @(posedge clk);
    if (!r) begin
      foreach (mvalid[i]) mvalid[i] = 1'b0;
    end else if (w && (wp % 2 == 0)) begin
      mvalid[(wp / 2) % 64] = 1'b1;
      mtag[(wp / 2) % 64]   = wp / 128;
      mtgt[(wp / 2) % 64]   = wt;
    end
  endtask

  // Idle cycle with lookups checked against hand-derived constants.
  task automatic probe(input int pa, input int pb, input bit eha, input int eta,
                       input bit ehb, input int etb);
    @(negedge clk);
    rst_n = 1'b1; we = 1'b0; pc_a = 16'(pa); pc_b = 16'(pb);
    #1;
    checkOutput("const_hit_a", 32'(hit_a), 32'(eha));
    checkOutput("const_tgt_a", 32'(tgt_a), 32'(eta));
    checkOutput("const_hit_b", 32'(hit_b), 32'(ehb));
    checkOutput("const_tgt_b", 32'(tgt_b), 32'(etb));
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; wpc = '0; wtgt = '0; pc_a = '0; pc_b = '0;
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    repeat (2) @(posedge clk);

    // Post-reset misses.
    probe(16'h0010, 16'h0200, 0, 16'h0012, 0, 16'h0202);

    // Write with same-cycle lookup seeing old contents, then new contents.
    applyStimulus(1, 1, 16'h0010, 16'h0004, 16'h0010, 16'h0200);
    probe(16'h0010, 16'h0011, 1, 16'h0004, 0, 16'h0013);

    // Alias eviction at the same index.
    applyStimulus(1, 1, 16'h0090, 16'h0100, 16'h0010, 16'h0090);
    probe(16'h0010, 16'h0090, 0, 16'h0012, 1, 16'h0100);

    // Dual port on idx 1 and idx 2, then both ports on the same PC.
    applyStimulus(1, 1, 16'h0002, 16'h1234, 16'h0002, 16'h0004);
    applyStimulus(1, 1, 16'h0004, 16'h5678, 16'h0002, 16'h0004);
    probe(16'h0002, 16'h0004, 1, 16'h1234, 1, 16'h5678);
    probe(16'h0004, 16'h0004, 1, 16'h5678, 1, 16'h5678);

    // Reset beats a simultaneous write.
    applyStimulus(0, 1, 16'h0020, 16'h0AAA, 16'h0020, 16'h0090);
    probe(16'h0020, 16'h0090, 0, 16'h0022, 0, 16'h0092);
    probe(16'h0002, 16'h0004, 0, 16'h0004, 0, 16'h0006);

    // Odd write ignored, wrap-around miss, then a hit at the top of memory.
    applyStimulus(1, 1, 16'h0031, 16'h0777, 16'h0030, 16'h0031);
    probe(16'h0030, 16'hFFFE, 0, 16'h0032, 0, 16'h0000);
    applyStimulus(1, 1, 16'hFFFE, 16'h0000, 16'hFFFE, 16'hFFFF);
    probe(16'hFFFE, 16'hFFFF, 1, 16'h0000, 0, 16'h0001);

    // Random traffic over a small tag pool so hits, aliases and evictions occur.
    for (int n = 0; n < 400; n++) begin
      int wp, pa, pb;
      wp = ($urandom_range(0, 3) * 128) + ($urandom_range(0, 15) * 2) + ($urandom_range(0, 7) == 0 ? 1 : 0);
      pa = ($urandom_range(0, 3) * 128) + ($urandom_range(0, 15) * 2) + ($urandom_range(0, 7) == 0 ? 1 : 0);
      pb = ($urandom_range(0, 3) * 128) + ($urandom_range(0, 15) * 2) + ($urandom_range(0, 7) == 0 ? 1 : 0);
      if ($urandom_range(0, 9) == 0) pb = pa;
      if ($urandom_range(0, 19) == 0) pa = 16'hFFFE;
      applyStimulus($urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1,
                    wp, int'($urandom_range(0, 65535)), pa, pb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
